p2s_converter: RTL and testbench
================================

// Module: p2s_converter
// PURPOSE
//  Parallel-to-serial converter with valid/ready handshakes on both sides.
//  Accepts an N-bit word on the parallel port and emits it one bit per
//  accepted serial beat. Sits between a word-wide producer and a 1-bit
//  serial consumer; one word in flight at a time.
// PARAMETERS
//  N          4   parallel word width in bits (N >= 2)
//  MSB_FIRST  0   0: bit 0 transmitted first; 1: bit N-1 transmitted first
// PORTS
//  clk        in   1   single clock; all state changes on rising edge
//  rstn       in   1   reset, synchronous, active-high (asserted when 1)
//  par_data   in   N   parallel word; sampled only on the accept edge
//  par_valid  in   1   producer has a word on par_data
//  par_ready  out  1   converter can accept a word (idle)
//  ser_data   out  1   current serial bit
//  ser_valid  out  1   ser_data holds a valid bit
//  ser_ready  in   1   consumer takes ser_data this cycle
// BEHAVIOUR
//  - All outputs registered. While rstn=1 at an edge: state=IDLE,
//    shift register=0, bit counter=0, ser_valid=0, ser_data=0, par_ready=0.
//    First edge with rstn=0: par_ready goes 1.
//  - States: IDLE (par_ready=1, ser_valid=0), SHIFT (par_ready=0, ser_valid=1).
//  - Parallel accept: edge where state=IDLE and par_valid=1 -> load par_data
//    into shift register, counter=N, go SHIFT. Next cycle: ser_valid=1,
//    ser_data = first bit (bit 0, or bit N-1 if MSB_FIRST), par_ready=0.
//  - par_valid=0 in IDLE: nothing happens; par_data ignored.
//  - Serial beat: edge with ser_valid=1 and ser_ready=1 -> present next bit,
//    counter decrements. ser_ready=0: ser_data/ser_valid held stable, no bit
//    lost or repeated, stalls indefinitely.
//  - Last beat (counter=1, ser_ready=1): next cycle IDLE, ser_valid=0,
//    ser_data=0, par_ready=1.
//  - Latency: accept edge -> first bit valid 1 cycle later. With ser_ready
//    held high a word occupies N cycles of ser_valid; throughput one word per
//    N+1 cycles (one IDLE cycle between words, no back-to-back overlap).
//  - par_valid while in SHIFT is ignored (par_ready=0); producer must hold.
//  - ser_ready high while ser_valid=0: no effect.
//  - Reset mid-word: word discarded, outputs go to reset values next edge.
//  - No data transformation; each accepted bit equals the stored word bit.
// TESTING
//  1 Reset held 2 cycles -> ser_valid=0, ser_data=0, par_ready=0; release ->
//    par_ready=1 next cycle.
//  2 par_data=7, par_valid=0, ser_ready=1 for 4 cycles -> no transfer,
//    ser_valid stays 0, par_ready stays 1.
//  3 par_data=11 (1011), par_valid pulsed 1 cycle, ser_ready=1 -> ser_data
//    1,1,0,1 on 4 consecutive cycles with ser_valid=1, then par_ready=1.
//  4 par_data=14 (1110) accepted, ser_ready dropped to 0 for 3 cycles after
//    first beat -> sequence 0,1,1,1 delivered intact; bit held during stall.
//  5 Second par_valid while SHIFT -> ignored, par_ready=0; word accepted
//    only after return to IDLE.
//  6 rstn asserted during SHIFT of 11 -> next cycle ser_valid=0; after
//    release new word 5 (0101) serialises as 1,0,1,0; MSB_FIRST=1 gives 0,1,0,1.

Source files
------------

// File: rtl/p2s_converter.sv
// Parallel-to-serial converter: accepts one N-bit word on a valid/ready port
// and emits it one bit per accepted serial beat, one word in flight at a time.
module p2s_converter #(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] par_data,
  input  logic         par_valid,
  output logic         par_ready,
  output logic         ser_data,
  output logic         ser_valid,
  input  logic         ser_ready
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         r_state;
  logic [N-1:0]   r_shift;
  logic [CW-1:0]  r_cnt;

  logic [N-1:0]   w_next;
  logic           w_next_bit;
  logic           w_first;
  logic           w_beat;
  logic           w_last;

  // The bit on ser_data always sits at the outgoing end of r_shift, so the
  // next bit is simply the one shifted into that position.
  assign w_next     = MSB_FIRST ? (r_shift << 1) : (r_shift >> 1);
  assign w_next_bit = MSB_FIRST ? w_next[N-1] : w_next[0];
  assign w_first    = MSB_FIRST ? par_data[N-1] : par_data[0];
  assign w_beat     = ser_valid && ser_ready;
  assign w_last     = (r_cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      ser_valid <= 1'b0;
      ser_data  <= 1'b0;
      par_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // par_ready rises here on the first edge out of reset
          par_ready <= 1'b1;
          if (par_valid && par_ready) begin
            r_state   <= SHIFT;
            r_shift   <= par_data;
            r_cnt     <= CW'(N);
            ser_valid <= 1'b1;
            ser_data  <= w_first;
            par_ready <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_beat) begin
            if (w_last) begin
              r_state   <= IDLE;
              r_cnt     <= '0;
              ser_valid <= 1'b0;
              ser_data  <= 1'b0;
              par_ready <= 1'b1;
            end else begin
              r_shift   <= w_next;
              r_cnt     <= r_cnt - CW'(1);
              ser_data  <= w_next_bit;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          ser_valid <= 1'b0;
          ser_data  <= 1'b0;
          par_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p2s_converter.sv
// Directed bench for p2s_converter: LSB-first and MSB-first instances share
// the same stimulus and are checked against hand-computed bit sequences.
module tb_p2s_converter;

  logic       clk;
  logic       rstn;
  logic [3:0] par_data;
  logic       par_valid;
  logic       ser_ready;
  logic       l_par_ready, l_ser_data, l_ser_valid;
  logic       m_par_ready, m_ser_data, m_ser_valid;

  int n_vec;
  int n_err;

  p2s_converter #(.N(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rstn(rstn), .par_data(par_data), .par_valid(par_valid),
    .par_ready(l_par_ready), .ser_data(l_ser_data), .ser_valid(l_ser_valid),
    .ser_ready(ser_ready)
  );

  p2s_converter #(.N(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rstn(rstn), .par_data(par_data), .par_valid(par_valid),
    .par_ready(m_par_ready), .ser_data(m_ser_data), .ser_valid(m_ser_valid),
    .ser_ready(ser_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag, input logic rdy);
    chk({tag, ".l.valid"}, l_ser_valid, 1'b0);
    chk({tag, ".l.data"},  l_ser_data,  1'b0);
    chk({tag, ".l.ready"}, l_par_ready, rdy);
    chk({tag, ".m.valid"}, m_ser_valid, 1'b0);
    chk({tag, ".m.data"},  m_ser_data,  1'b0);
    chk({tag, ".m.ready"}, m_par_ready, rdy);
  endtask

  task automatic chk_bit(input string tag, input logic el, input logic em);
    chk({tag, ".l.valid"}, l_ser_valid, 1'b1);
    chk({tag, ".l.data"},  l_ser_data,  el);
    chk({tag, ".l.ready"}, l_par_ready, 1'b0);
    chk({tag, ".m.valid"}, m_ser_valid, 1'b1);
    chk({tag, ".m.data"},  m_ser_data,  em);
    chk({tag, ".m.ready"}, m_par_ready, 1'b0);
  endtask

  // seq[k] is the k-th bit expected on the wire. Optional stall of
  // stall_len cycles with ser_ready low while bit stall_at is presented.
  task automatic chk_seq(input string tag, input logic [3:0] sl,
                         input logic [3:0] sm, input int stall_at,
                         input int stall_len);
    for (int k = 0; k < 4; k++) begin
      if (k == stall_at) begin
        ser_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          chk_bit($sformatf("%s.stall%0d", tag, s), sl[k], sm[k]);
          tick();
        end
        ser_ready = 1'b1;
      end
      chk_bit($sformatf("%s.b%0d", tag, k), sl[k], sm[k]);
      tick();
    end
    chk_idle({tag, ".end"}, 1'b1);
  endtask

  task automatic send(input logic [3:0] w);
    par_data  = w;
    par_valid = 1'b1;
    ser_ready = 1'b1;
    tick();
    par_valid = 1'b0;
    par_data  = 4'h0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rstn      = 1'b1;
    par_data  = 4'h0;
    par_valid = 1'b0;
    ser_ready = 1'b0;

    // 1: reset held two cycles, then released
    tick();
    tick();
    chk_idle("rst", 1'b0);
    rstn = 1'b0;
    tick();
    chk_idle("rst_rel", 1'b1);

    // 2: par_valid low, no transfer
    par_data  = 4'd7;
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle($sformatf("noval%0d", i), 1'b1);
    end

    // 3: word 11 (1011): LSB 1,1,0,1 / MSB 1,0,1,1
    send(4'd11);
    chk_seq("w11", 4'b1011, 4'b1101, -1, 0);

    // 4: word 14 (1110) with 3-cycle stall after first beat
    //    LSB 0,1,1,1 / MSB 1,1,1,0
    send(4'd14);
    chk_seq("w14", 4'b1110, 4'b0111, 1, 3);

    // 5: par_valid held through SHIFT with a new word on the bus
    par_data  = 4'd11;
    par_valid = 1'b1;
    ser_ready = 1'b1;
    tick();
    par_data = 4'd5;
    for (int k = 0; k < 4; k++) begin
      chk_bit($sformatf("hold.b%0d", k), k != 2, k != 1);
      tick();
    end
    chk_idle("hold.end", 1'b1);
    tick();
    par_valid = 1'b0;
    par_data  = 4'h0;
    // 5 (0101): LSB 1,0,1,0 / MSB 0,1,0,1
    chk_seq("hold.w5", 4'b0101, 4'b1010, -1, 0);

    // 6: reset in the middle of word 11
    send(4'd11);
    chk_bit("mid.b0", 1'b1, 1'b1);
    tick();
    chk_bit("mid.b1", 1'b1, 1'b0);
    rstn = 1'b1;
    tick();
    chk_idle("mid.rst", 1'b0);
    rstn = 1'b0;
    tick();
    chk_idle("mid.rel", 1'b1);
    send(4'd5);
    chk_seq("mid.w5", 4'b0101, 4'b1010, -1, 0);

    // ser_ready high while idle has no effect
    tick();
    chk_idle("idle_rdy", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
